spi_game_link: RTL
==================

SPI_GAME_LINK -- requirements
Module: spi_game_link

Interface
REQ-001 Parameter SYNC_STAGES, default 2, number of flip-flops synchronizing iSPI_SCK, iSPI_CS_n and iSPI_MOSI into iCLK (legal 2..3).
REQ-002 Parameter ID_BYTE, default 8'hA5, value returned on a read of address 3.
REQ-003 iCLK  input  1  system clock, LCD control clock domain (33 MHz nominal).
REQ-004 iRST_n  input  1  asynchronous, active-low reset.
REQ-005 iSPI_SCK  input  1  SPI clock from PIC32, mode 0, at most iCLK/8.
REQ-006 iSPI_CS_n  input  1  SPI chip select, active low.
REQ-007 iSPI_MOSI  input  1  SPI data in, MSB first.
REQ-008 oSPI_MISO  output  1  SPI data out, MSB first.
REQ-009 oSPI_game_status  output  8  game status register, feeds the MTL controller iSPI_game_status.
REQ-010 oSPI_jump  output  8  jump command register, feeds iSPI_jump.
REQ-011 oSPI_acc  output  8  accelerometer register, feeds iSPI_acc.
REQ-012 oUpdate  output  1  one-cycle pulse when any register is written.
REQ-013 oFrame_err  output  1  one-cycle pulse on an aborted transaction.

Function
REQ-014 The block SHALL synchronize SCK, CS_n and MOSI through SYNC_STAGES flip-flops and detect SCK rising/falling edges on the synchronized signal only.
REQ-015 A transaction SHALL be CS_n low, 16 SCK rising edges, CS_n high: byte 0 = command {bit7 W/R_n, bits6:2 ignored, bits1:0 address}, byte 1 = data.
REQ-016 The FSM SHALL have states IDLE, CMD, DATA, HOLD; IDLE->CMD on synchronized CS_n falling, CMD->DATA after 8th rising edge, DATA->HOLD after 16th rising edge, any state->IDLE on CS_n high.
REQ-017 MOSI SHALL be sampled on synchronized SCK rising edges into an 8-bit shift register; a 4-bit bit counter SHALL count rising edges and reset on CS_n falling.
REQ-018 Addresses SHALL map 0 -> game_status, 1 -> jump, 2 -> acc, 3 -> read-only ID_BYTE.
REQ-019 On a write to address 0..2 the target register and oUpdate SHALL update on the same iCLK cycle, exactly one cycle after the 16th synchronized rising edge is detected.
REQ-020 A write to address 3 SHALL change no register and SHALL NOT pulse oUpdate.
REQ-021 In DATA during a read, oSPI_MISO SHALL present the addressed register MSB first, first bit valid before the 9th rising edge, next bit shifted on each synchronized falling edge.
REQ-022 oSPI_MISO SHALL be 0 in IDLE, CMD and HOLD and during write transactions.
REQ-023 CS_n rising with bit counter not 0 and not 16 SHALL discard the transaction, change no register, and pulse oFrame_err once.
REQ-024 SCK edges in HOLD (beyond 16) SHALL be ignored; no second write, no oFrame_err.
REQ-025 CS_n rising and the 16th rising edge detected in the same cycle SHALL commit the write (transaction complete).
REQ-026 SCK edges while CS_n is high SHALL be ignored.
REQ-027 Registers SHALL hold value until overwritten; there is no clear-on-read.

Reset
REQ-028 iRST_n low SHALL asynchronously force FSM to IDLE, bit counter and shift registers to 0, synchronizers to idle levels (SCK 0, CS_n 1, MOSI 0).
REQ-029 During and after reset all three registers, oSPI_MISO, oUpdate and oFrame_err SHALL be 0.
REQ-030 Reset asserted mid-transaction SHALL abort without oFrame_err; the first transaction after release SHALL start from a new CS_n falling edge.

Configuration
REQ-031 Macro SPI_GAME_LINK_READBACK_EN: when defined, reads behave per REQ-021; when undefined, oSPI_MISO is constant 0, read commands change nothing, and the MISO shift logic is not synthesized.

Verification
REQ-032 Write 8'h80,8'h3C (W, addr0) -> oSPI_game_status=8'h3C, one oUpdate pulse, others 0.
REQ-033 Write 8'h82,8'hF1 then read 8'h02,xx -> MISO shifts 8'hF1 in byte 1 (READBACK_EN defined); 8'h00 when undefined.
REQ-034 Read 8'h03,xx -> MISO returns 8'hA5; write 8'h83,8'h11 -> no register change, no oUpdate.
REQ-035 Write 8'h81 then CS_n high after 11 edges -> oSPI_jump unchanged, one oFrame_err pulse.
REQ-036 Write 8'h81,8'h05 then 8 extra SCK edges before CS_n high -> oSPI_jump=8'h05, exactly one oUpdate.
REQ-037 iRST_n low after 12 edges of a write 8'h80,8'hFF -> all outputs 0, no oFrame_err; next full write 8'h80,8'h07 -> game_status=8'h07.

Source files
------------

// File: rtl/spi_game_link.sv
// spi_game_link: mode-0 SPI slave carrying PIC32 game state (status, jump, acc) into the LCD clock domain.
// Define SPI_GAME_LINK_READBACK_EN to build the MISO readback path; otherwise MISO is tied low.
module spi_game_link #(
   parameter int unsigned SYNC_STAGES = 2,
   parameter logic [7:0]  ID_BYTE     = 8'hA5
) (
   input  logic       iCLK,
   input  logic       iRST_n,
   input  logic       iSPI_SCK,
   input  logic       iSPI_CS_n,
   input  logic       iSPI_MOSI,
   output logic       oSPI_MISO,
   output logic [7:0] oSPI_game_status,
   output logic [7:0] oSPI_jump,
   output logic [7:0] oSPI_acc,
   output logic       oUpdate,
   output logic       oFrame_err
);

   typedef enum logic [1:0] {IDLE, CMD, DATA, HOLD} state_t;

   logic [SYNC_STAGES-1:0] sck_sync_reg;
   logic [SYNC_STAGES-1:0] cs_sync_reg;
   logic [SYNC_STAGES-1:0] mosi_sync_reg;
   logic                   sck_prev_reg;
   logic                   cs_prev_reg;

   logic sck_s, cs_s, mosi_s;
   logic sck_rise, cs_fall;

   state_t     state_reg;
   logic [3:0] bit_cnt_reg;
   logic [7:0] shift_reg;
   logic       cmd_wr_reg;
   logic [1:0] cmd_addr_reg;
   logic       update_reg;
   logic       frame_err_reg;

   logic [7:0] shift_next;
   logic       cmd_edge, last_edge, wr_commit, abort;

   // Synchronizers reset to the bus idle levels so no spurious edge follows reset.
   always_ff @(posedge iCLK or negedge iRST_n) begin
      if (!iRST_n) begin
         sck_sync_reg  <= '0;
         cs_sync_reg   <= '1;
         mosi_sync_reg <= '0;
         sck_prev_reg  <= 1'b0;
         cs_prev_reg   <= 1'b1;
      end else begin
         sck_sync_reg  <= {sck_sync_reg[SYNC_STAGES-2:0], iSPI_SCK};
         cs_sync_reg   <= {cs_sync_reg[SYNC_STAGES-2:0], iSPI_CS_n};
         mosi_sync_reg <= {mosi_sync_reg[SYNC_STAGES-2:0], iSPI_MOSI};
         sck_prev_reg  <= sck_s;
         cs_prev_reg   <= cs_s;
      end
   end

   assign sck_s    = sck_sync_reg[SYNC_STAGES-1];
   assign cs_s     = cs_sync_reg[SYNC_STAGES-1];
   assign mosi_s   = mosi_sync_reg[SYNC_STAGES-1];
   assign sck_rise = sck_s & ~sck_prev_reg;
   assign cs_fall  = ~cs_s & cs_prev_reg;

   assign shift_next = {shift_reg[6:0], mosi_s};
   assign cmd_edge   = (state_reg == CMD)  && sck_rise && (bit_cnt_reg == 4'd7);
   assign last_edge  = (state_reg == DATA) && sck_rise && (bit_cnt_reg == 4'd15);
   assign wr_commit  = last_edge && cmd_wr_reg && (cmd_addr_reg != 2'd3);

   // A 16th edge landing together with CS_n high still completes the frame.
   assign abort = cs_s && !last_edge &&
                  ((state_reg == DATA) ||
                   ((state_reg == CMD) && ((bit_cnt_reg != 4'd0) || sck_rise)));

   always_ff @(posedge iCLK or negedge iRST_n) begin
      if (!iRST_n) begin
         state_reg     <= IDLE;
         bit_cnt_reg   <= 4'd0;
         shift_reg     <= 8'h00;
         cmd_wr_reg    <= 1'b0;
         cmd_addr_reg  <= 2'd0;
         update_reg    <= 1'b0;
         frame_err_reg <= 1'b0;
      end else begin
         update_reg    <= wr_commit;
         frame_err_reg <= abort;
         if ((state_reg != IDLE) && cs_s) begin
            state_reg <= IDLE;
         end else begin
            case (state_reg)
               IDLE: begin
                  if (cs_fall) begin
                     state_reg   <= CMD;
                     bit_cnt_reg <= 4'd0;
                     shift_reg   <= 8'h00;
                  end
               end
               CMD, DATA: begin
                  if (sck_rise) begin
                     shift_reg   <= shift_next;
                     bit_cnt_reg <= bit_cnt_reg + 4'd1;
                     if (cmd_edge) begin
                        cmd_wr_reg   <= shift_next[7];
                        cmd_addr_reg <= shift_next[1:0];
                        state_reg    <= DATA;
                     end
                     if (last_edge) begin
                        state_reg <= HOLD;
                     end
                  end
               end
               default: ;
            endcase
         end
      end
   end

   // Register bank: the write lands on the cycle after the 16th edge is seen.
   genvar gi;
   for (gi = 0; gi < 3; gi++) begin : g_reg
      logic [7:0] value_reg;
      always_ff @(posedge iCLK or negedge iRST_n) begin
         if (!iRST_n) begin
            value_reg <= 8'h00;
         end else if (wr_commit && (cmd_addr_reg == 2'(gi))) begin
            value_reg <= shift_next;
         end
      end
   end

   assign oSPI_game_status = g_reg[0].value_reg;
   assign oSPI_jump        = g_reg[1].value_reg;
   assign oSPI_acc         = g_reg[2].value_reg;
   assign oUpdate          = update_reg;
   assign oFrame_err       = frame_err_reg;

`ifdef SPI_GAME_LINK_READBACK_EN
   logic       sck_fall;
   logic [7:0] read_value;
   logic [7:0] miso_shift_reg;
   logic       read_active_reg;

   assign sck_fall = ~sck_s & sck_prev_reg;

   always_comb begin
      case (shift_next[1:0])
         2'd0:    read_value = g_reg[0].value_reg;
         2'd1:    read_value = g_reg[1].value_reg;
         2'd2:    read_value = g_reg[2].value_reg;
         default: read_value = ID_BYTE;
      endcase
   end

   // Loaded at the 8th edge; the falling edge right after it is skipped so bit 7 is seen on edge 9.
   always_ff @(posedge iCLK or negedge iRST_n) begin
      if (!iRST_n) begin
         miso_shift_reg  <= 8'h00;
         read_active_reg <= 1'b0;
      end else if (cs_s || last_edge) begin
         miso_shift_reg  <= 8'h00;
         read_active_reg <= 1'b0;
      end else if (cmd_edge) begin
         read_active_reg <= ~shift_next[7];
         miso_shift_reg  <= shift_next[7] ? 8'h00 : read_value;
      end else if (read_active_reg && sck_fall && (bit_cnt_reg != 4'd8)) begin
         miso_shift_reg <= {miso_shift_reg[6:0], 1'b0};
      end
   end

   assign oSPI_MISO = read_active_reg & miso_shift_reg[7];
`else
   logic unused_id;
   assign unused_id = ^ID_BYTE;
   assign oSPI_MISO = 1'b0;
`endif

endmodule
